ov7670_pattern_gen: RTL and testbench

Synthesizable OV7670 camera emulator: from `clk_24` it drives the sensor-side pixel bus, which is `pclk`, `vsync`, `href` and 8-bit `data`. Pixels are RGB565, sent as two bytes per pixel, MSB first. It replaces the physical sensor in simulation and in board bring-up, so the camera capture block and the frame-buffer path can be exercised with known images. Output timing follows OV7670 conventions:
- `vsync` is an active-high pulse while `href` is low.
- `href` is high only during active bytes.
- `data` changes on the falling edge of `pclk`.

---
 rtl/ov7670_pattern_gen_if.sv | 10 +
 rtl/ov7670_pattern_gen.sv | 182 ++++++++++++++++++
 tb/tb_ov7670_pattern_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pattern_gen_if.sv
// OV7670 sensor-side pixel bus: byte clock, frame/line syncs and the pixel byte.
interface ov7670_pattern_gen_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output pclk, vsync, href, data);
  modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// OV7670 camera emulator: streams RGB565 test patterns (two bytes per pixel, MSB first)
// with sensor-style vsync/href timing, all bus changes landing on the falling edge of pclk.
module ov7670_pattern_gen #(
  parameter int H_ACTIVE    = 174,
  parameter int V_ACTIVE    = 144,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic                        clk_24,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [1:0]                  pattern,
  input  logic [15:0]                 solid_color,
  ov7670_pattern_gen_if.master        cam,
  output logic                        frame_done,
  output logic [15:0]                 frame_count,
  output logic                        busy
);

  localparam int          LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
  localparam int          BAR_W      = H_ACTIVE / 8;
  localparam logic [15:0] LAST_BC    = 16'(LINE_BYTES - 1);
  localparam logic [15:0] ACT_BYTES  = 16'(2 * H_ACTIVE);
  localparam logic [15:0] BAR_LAST   = 16'(BAR_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  logic        ph;
  logic [2:0]  state, nxt_state;
  logic [15:0] bc, nxt_bc, lc, nxt_lc, seg_last;
  logic [15:0] bar_cnt, nxt_bar_cnt;
  logic [2:0]  bar_idx, nxt_bar_idx;
  logic [1:0]  pat_q;
  logic [15:0] solid_q;
  logic        start_frame, end_frame;
  logic        vsync_q, href_q;
  logic [7:0]  data_q;
  logic [7:2]  px;
  logic [15:0] pixel;
  logic        nxt_href;
  logic [7:0]  nxt_data;

  always_comb begin
    case (state)
      S_VSYNC:  seg_last = 16'(VSYNC_LINES - 1);
      S_VBACK:  seg_last = 16'(V_BACK - 1);
      S_ACTIVE: seg_last = 16'(V_ACTIVE - 1);
      default:  seg_last = 16'(V_FRONT - 1);
    endcase
  end

  // Position (state, byte, line) that the next tick moves to; outputs are derived from it.
  always_comb begin
    nxt_state   = state;
    nxt_bc      = bc;
    nxt_lc      = lc;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    if (state == S_IDLE) begin
      if (enable) begin
        nxt_state   = S_VSYNC;
        nxt_bc      = 16'd0;
        nxt_lc      = 16'd0;
        start_frame = 1'b1;
      end
    end else if (bc != LAST_BC) begin
      nxt_bc = bc + 16'd1;
    end else begin
      nxt_bc = 16'd0;
      nxt_lc = lc + 16'd1;
      if (lc == seg_last) begin
        nxt_lc = 16'd0;
        case (state)
          S_VSYNC:  nxt_state = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
          S_VBACK:  nxt_state = S_ACTIVE;
          S_ACTIVE: begin
            if (V_FRONT > 0) nxt_state = S_VFRONT;
            else             end_frame = 1'b1;
          end
          default:  end_frame = 1'b1;
        endcase
        if (end_frame) begin
          nxt_state   = enable ? S_VSYNC : S_IDLE;
          start_frame = enable;
        end
      end
    end
  end

  // Bar index advances every BAR_W pixels and saturates at the last bar, avoiding a divider.
  always_comb begin
    nxt_bar_idx = bar_idx;
    nxt_bar_cnt = bar_cnt;
    if (nxt_bc == 16'd0) begin
      nxt_bar_idx = 3'd0;
      nxt_bar_cnt = 16'd0;
    end else if (!nxt_bc[0]) begin
      if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
        nxt_bar_idx = bar_idx + 3'd1;
        nxt_bar_cnt = 16'd0;
      end else begin
        nxt_bar_cnt = bar_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    px = nxt_bc[8:3];
    case (pat_q)
      2'd0: begin
        case (nxt_bar_idx)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {px[7:3], px[7:2], px[7:3]};
      2'd2:    pixel = (px[3] ^ nxt_lc[3]) ? 16'hFFFF : 16'h0000;
      default: pixel = solid_q;
    endcase
    nxt_href = (nxt_state == S_ACTIVE) && (nxt_bc < ACT_BYTES);
    nxt_data = nxt_href ? (nxt_bc[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
  end

  // Everything except the phase and the frame_done clear moves only on ticks (ph=1, pclk falling).
  always_ff @(posedge clk_24) begin
    if (reset) begin
      ph          <= 1'b0;
      state       <= S_IDLE;
      bc          <= 16'd0;
      lc          <= 16'd0;
      bar_idx     <= 3'd0;
      bar_cnt     <= 16'd0;
      pat_q       <= 2'd0;
      solid_q     <= 16'd0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      ph         <= ~ph;
      frame_done <= 1'b0;
      if (ph) begin
        state   <= nxt_state;
        bc      <= nxt_bc;
        lc      <= nxt_lc;
        bar_idx <= nxt_bar_idx;
        bar_cnt <= nxt_bar_cnt;
        vsync_q <= (nxt_state == S_VSYNC);
        href_q  <= nxt_href;
        data_q  <= nxt_data;
        if (start_frame) begin
          pat_q   <= pattern;
          solid_q <= solid_color;
        end
        if (end_frame) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  assign cam.pclk  = ph;
  assign cam.vsync = vsync_q;
  assign cam.href  = href_q;
  assign cam.data  = data_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// Scoreboard bench for ov7670_pattern_gen: expected pixel bytes are queued per frame and
// popped by a pclk-rising-edge monitor; frame geometry and control are checked in line.
module tb_ov7670_pattern_gen;

  localparam int H     = 16;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int LINE  = 2 * H + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LINE;
  localparam logic [15:0] BAR [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        clk_24 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  ov7670_pattern_gen_if cam ();

  ov7670_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk_24(clk_24), .reset(reset), .enable(enable), .pattern(pattern),
    .solid_color(solid_color), .cam(cam), .frame_done(frame_done),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk_24 = ~clk_24;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int run_len = 0, pulses = 0, vs_ticks = 0, both_bad = 0, blank_bad = 0;
  int done_pulses = 0, cyc = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] pat, input logic [15:0] sc, input logic en);
    pattern     = pat;
    solid_color = sc;
    enable      = en;
  endtask

  function automatic logic [15:0] expPixel(input int pat, input int x, input int y,
                                           input logic [15:0] sc);
    logic [7:0] xb, yb;
    int bar;
    xb  = 8'(x);
    yb  = 8'(y);
    bar = x / (H / 8);
    if (bar > 7) bar = 7;
    case (pat)
      0:       return BAR[bar];
      1:       return {xb[7:3], xb[7:2], xb[7:3]};
      2:       return (xb[3] ^ yb[3]) ? 16'hFFFF : 16'h0000;
      default: return sc;
    endcase
  endfunction

  task automatic pushFrame(input int pat, input logic [15:0] sc);
    logic [15:0] p;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < H; x++) begin
        p = expPixel(pat, x, y, sc);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
  endtask

  task automatic step();
    @(posedge clk_24);
    #1;
  endtask

  task automatic waitVsync(output int lat);
    lat = 0;
    while (!cam.vsync && lat < 8) begin
      step();
      lat++;
    end
  endtask

  task automatic waitHref();
    int n;
    n = 0;
    while (!cam.href && n < 4 * FRAME) begin
      step();
      n++;
    end
    checkOutput("href seen", cam.href, 1);
  endtask

  task automatic waitFrameDone();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 4 * FRAME);
    checkOutput("frame_done seen", frame_done, 1);
  endtask

  always @(posedge clk_24) begin
    cyc++;
    #1;
    if (frame_done) done_pulses++;
  end

  // Monitor: every pclk rising edge is one byte period; href bytes are scored against the queue.
  always @(posedge cam.pclk) begin
    #1;
    if (cam.vsync) vs_ticks++;
    if (cam.vsync && cam.href) both_bad++;
    if (cam.href) begin
      run_len++;
      if (exp_q.size() == 0) checkOutput("expected bytes left", exp_q.size(), 1);
      else checkOutput("pixel byte", cam.data, exp_q.pop_front());
    end else begin
      if (run_len != 0) begin
        checkOutput("href pulse bytes", run_len, 2 * H);
        pulses++;
        run_len = 0;
      end
      if (cam.data != 8'h00) blank_bad++;
    end
  end

  initial begin
    int lat, exp_lat, t0, bad_pclk, idle_bad;
    logic prev_pclk;

    applyStimulus(2'd0, 16'h0000, 1'b0);
    reset = 1'b1;
    repeat (4) step();
    checkOutput("reset pclk", cam.pclk, 0);
    checkOutput("reset vsync", cam.vsync, 0);
    checkOutput("reset href", cam.href, 0);
    checkOutput("reset data", cam.data, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_count", frame_count, 0);
    checkOutput("reset frame_done", frame_done, 0);

    reset = 1'b0;
    bad_pclk = 0;
    idle_bad = 0;
    prev_pclk = cam.pclk;
    repeat (1000) begin
      step();
      if (cam.pclk == prev_pclk) bad_pclk++;
      prev_pclk = cam.pclk;
      if (cam.vsync || cam.href || cam.data != 8'h00 || busy || frame_count != 16'd0) idle_bad++;
    end
    checkOutput("idle pclk toggling", bad_pclk, 0);
    checkOutput("idle outputs quiet", idle_bad, 0);

    // Back-to-back frames: bars, then grey ramp picked up at the frame boundary.
    pushFrame(0, 16'h0000);
    pushFrame(1, 16'h0000);
    exp_lat = cam.pclk ? 1 : 2;
    applyStimulus(2'd0, 16'h0000, 1'b1);
    waitVsync(lat);
    checkOutput("vsync start latency", lat, exp_lat);
    t0 = cyc;
    applyStimulus(2'd1, 16'h0000, 1'b1);
    waitFrameDone();
    checkOutput("frame length cycles", cyc - t0, 2 * FRAME);
    checkOutput("frame_count after 1", frame_count, 1);
    checkOutput("vsync ticks frame 1", vs_ticks, VS * LINE);
    checkOutput("href pulses frame 1", pulses, VA);
    step();
    checkOutput("frame_done width", frame_done, 0);
    done_pulses = 0;

    waitHref();
    applyStimulus(2'd1, 16'h0000, 1'b0);
    waitFrameDone();
    checkOutput("frame_count after 2", frame_count, 2);
    repeat (20) step();
    checkOutput("single frame_done after drop", done_pulses, 1);
    checkOutput("busy after drop", busy, 0);
    checkOutput("bytes left after 2", exp_q.size(), 0);
    checkOutput("vsync ticks 2 frames", vs_ticks, 2 * VS * LINE);
    checkOutput("href pulses 2 frames", pulses, 2 * VA);

    // Solid colour latched at frame start; the mid-frame change must not appear.
    pushFrame(3, 16'h1234);
    applyStimulus(2'd3, 16'h1234, 1'b1);
    waitVsync(lat);
    applyStimulus(2'd3, 16'hABCD, 1'b0);
    waitFrameDone();
    checkOutput("frame_count after 3", frame_count, 3);
    checkOutput("busy at end of solid", busy, 0);
    checkOutput("bytes left after 3", exp_q.size(), 0);

    pushFrame(2, 16'h0000);
    applyStimulus(2'd2, 16'h0000, 1'b1);
    waitVsync(lat);
    applyStimulus(2'd2, 16'h0000, 1'b0);
    waitFrameDone();
    checkOutput("frame_count after 4", frame_count, 4);
    checkOutput("bytes left after 4", exp_q.size(), 0);

    // Reset in the middle of an active line, then a fresh frame.
    pushFrame(2, 16'h0000);
    applyStimulus(2'd2, 16'h0000, 1'b1);
    waitHref();
    repeat (7) step();
    reset = 1'b1;
    step();
    checkOutput("mid-line reset href", cam.href, 0);
    checkOutput("mid-line reset data", cam.data, 0);
    checkOutput("mid-line reset vsync", cam.vsync, 0);
    checkOutput("mid-line reset busy", busy, 0);
    checkOutput("mid-line reset frame_count", frame_count, 0);
    step();
    exp_q.delete();
    run_len = 0;
    pushFrame(2, 16'h0000);
    reset = 1'b0;
    waitVsync(lat);
    checkOutput("restart vsync latency", lat, 2);
    applyStimulus(2'd2, 16'h0000, 1'b0);
    waitFrameDone();
    checkOutput("frame_count after restart", frame_count, 1);
    checkOutput("bytes left after restart", exp_q.size(), 0);

    checkOutput("vsync with href", both_bad, 0);
    checkOutput("blank data nonzero", blank_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
